// File: rtl/riscv_mdu_sequencer_if.sv
// Handshake bundle between the EX-stage pipeline control and the M-extension sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface riscv_mdu_sequencer_if #(
  parameter int XLEN = 64
);
  localparam int CW = $clog2(XLEN + 1);

  logic          valid_e;
  logic [2:0]    funct3_e;
  logic          wordop_e;
  logic          kill;
  logic          divzero;
  logic          ovf;
  logic          stall;
  logic          busy;
  logic          load;
  logic          step;
  logic          fix;
  logic          done;
  logic [1:0]    special;
  logic [CW-1:0] cnt;
  logic [2:0]    state;

  modport master (
    output valid_e, funct3_e, wordop_e, kill, divzero, ovf,
    input  stall, busy, load, step, fix, done, special, cnt, state
  );

  modport slave (
    input  valid_e, funct3_e, wordop_e, kill, divzero, ovf,
    output stall, busy, load, step, fix, done, special, cnt, state
  );
endinterface

// File: rtl/riscv_mdu_sequencer.sv
// Sequencer for the shared iterative multiply/divide datapath of the RV64 EX stage.
// Optional RISCV_MDSQ_EARLYOUT_EN: divide-by-zero/overflow divides skip DIV and FIX.
module riscv_mdu_sequencer #(
  parameter int XLEN     = 64,
  parameter int WORD_LEN = 32,
  parameter int MUL_LAT  = 3
) (
  input  logic                  i_riscv_mdsq_clk,
  input  logic                  i_riscv_mdsq_rst,
  riscv_mdu_sequencer_if.slave  bus
);
  localparam int CW = $clog2(XLEN + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_FIX  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);
  localparam logic [CW-1:0] CNT_WORD = CW'(WORD_LEN);
  localparam logic [CW-1:0] CNT_MUL  = CW'(MUL_LAT);

  logic [2:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    special_q;
  logic          is_div_q;

  // Only the divide/multiply selector bit of funct3 steers the sequence.
  logic unused_funct3;
  assign unused_funct3 = ^bus.funct3_e[1:0];

  // Handshake: an op is accepted in IDLE when valid_e is high and kill is low; once
  // accepted, valid_e/funct3/wordop are ignored until DONE. kill overrides everything.
  always_ff @(posedge i_riscv_mdsq_clk) begin
    if (i_riscv_mdsq_rst || bus.kill) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      special_q <= 2'b00;
      is_div_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.valid_e) begin
            state_q   <= S_LOAD;
            is_div_q  <= bus.funct3_e[2];
            special_q <= 2'b00;
            if (bus.funct3_e[2]) cnt_q <= bus.wordop_e ? CNT_WORD : CNT_FULL;
            else                 cnt_q <= CNT_MUL;
          end
        end
        S_LOAD: begin
          if (is_div_q) begin
            special_q <= bus.divzero ? 2'b01 : (bus.ovf ? 2'b10 : 2'b00);
`ifdef RISCV_MDSQ_EARLYOUT_EN
            if (bus.divzero || bus.ovf) begin
              state_q <= S_DONE;
              cnt_q   <= '0;
            end else begin
              state_q <= S_DIV;
            end
`else
            state_q <= S_DIV;
`endif
          end else begin
            special_q <= 2'b00;
            state_q   <= S_MUL;
          end
        end
        S_DIV: begin
          if (cnt_q <= CW'(1)) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_MUL: begin
          if (cnt_q <= CW'(1)) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_FIX: state_q <= S_DONE;
        S_DONE: begin
          // EX/M advances on this edge, so the finished op is never restarted.
          state_q   <= S_IDLE;
          special_q <= 2'b00;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.stall   = (((state_q == S_IDLE) && bus.valid_e) || (state_q == S_LOAD) ||
                        (state_q == S_DIV) || (state_q == S_MUL) || (state_q == S_FIX)) &&
                       !bus.kill;
  assign bus.load    = (state_q == S_LOAD) && !bus.kill;
  assign bus.step    = ((state_q == S_DIV) || (state_q == S_MUL)) && !bus.kill;
  assign bus.fix     = (state_q == S_FIX) && !bus.kill;
  assign bus.done    = (state_q == S_DONE) && !bus.kill;
  assign bus.special = special_q;
  assign bus.cnt     = cnt_q;
  assign bus.state   = state_q;
endmodule
